// File: rtl/fetch_pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator: redirect bus layout,
// default reset PC and the redirect FSM encoding.
package fetch_pc_gen_pkg;

  localparam int BR_WD = 33;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

  typedef enum logic [0:0] {
    ST_SEQ     = 1'b0,
    ST_BP_PEND = 1'b1
  } fetch_state_e;

  // Both redirect buses are {enable, target}.
  typedef struct packed {
    logic        e;
    logic [31:0] target;
  } redirect_t;

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Instruction-fetch bus between the PC generator (master) and instruction memory (slave).
interface fetch_pc_gen_if;
  // Handshake: a request is accepted in any cycle where inst_req and inst_addr_ok
  // are both high; inst_addr is stable while inst_req waits for inst_addr_ok.
  // inst_data_ok returns the oldest accepted request, strictly in order, at most
  // one per cycle, and only while at least one request is outstanding.
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok
  );
endinterface

// File: rtl/fetch_req_fifo.sv
// In-order tracking FIFO for outstanding fetch requests: each entry holds the
// request PC and a kill bit that suppresses its response.
module fetch_req_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [31:0]                push_pc,
  input  logic                       kill_push,
  input  logic                       kill_all,
  input  logic                       pop,
  output logic [31:0]                head_pc,
  output logic                       head_kill,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]    pc_q [DEPTH];
  logic [31:0]    pc_d [DEPTH];
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pc_d     = pc_q;
    kill_d   = kill_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop & (count_q != '0);
    do_push  = push & (count_q != CW'(DEPTH));
    // Marking free slots too is harmless: a push always rewrites its kill bit.
    if (kill_all) kill_d = '1;
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push) begin
      pc_d[wr_ptr_q]   = push_pc;
      kill_d[wr_ptr_q] = kill_push | kill_all;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kill_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      kill_q   <= kill_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(pop && count_q == '0))
        else $error("fetch_req_fifo: inst_data_ok with no outstanding request");
    end
  end

  assign head_pc   = pc_q[rd_ptr_q];
  assign head_kill = kill_q[rd_ptr_q];
  assign empty     = (count_q == '0);
  assign count     = count_q;

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: issues paired-instruction fetch requests, applies branch
// and predictor redirects, and tags returning data as live or killed.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [BR_WD-1:0]       br_bus,
  input  logic [BR_WD-1:0]       bp_bus,
  output logic [31:0]            current_pc1,
  output logic [31:0]            current_pc2,
  fetch_pc_gen_if.master         ibus,
  output logic                   resp_valid,
  output logic [31:0]            resp_pc,
  output fetch_state_e           state_dbg
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  redirect_t    br, bp;
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  bp_tgt_q, bp_tgt_d;
  logic         bp_arm_q, bp_arm_d;
  logic         last_acc_q, last_acc_d;
  logic         accept, bp_take, kill_all, kill_push;
  logic [31:0]  head_pc;
  logic         head_kill, fifo_empty;
  logic [CW-1:0] fifo_count;

  assign br = redirect_t'(br_bus);
  assign bp = redirect_t'(bp_bus);

  assign ibus.inst_req  = ~reset & ~stall & (fifo_count < CW'(FIFO_DEPTH));
  assign ibus.inst_addr = pc_q;
  assign accept         = ibus.inst_req & ibus.inst_addr_ok;
  // The predictor holds its output across a stall, so only the first cycle
  // after a non-stalled, non-redirected cycle carries a fresh prediction.
  assign bp_take        = bp.e & bp_arm_q & (state_q == ST_SEQ);

  always_comb begin
    pc_d      = pc_q;
    state_d   = state_q;
    bp_tgt_d  = bp_tgt_q;
    kill_all  = 1'b0;
    kill_push = 1'b0;
    if (br.e) begin
      pc_d     = br.target;
      state_d  = ST_SEQ;
      kill_all = 1'b1;
    end else if (state_q == ST_BP_PEND) begin
      if (accept) begin
        pc_d    = bp_tgt_q;
        state_d = ST_SEQ;
      end
    end else if (bp_take) begin
      if (last_acc_q) begin
        // Hit pair already issued; whatever follows it this cycle is wrong-path.
        pc_d      = bp.target;
        kill_push = accept;
      end else if (accept) begin
        // Hit pair is being issued right now, so redirect without waiting.
        pc_d = bp.target;
      end else begin
        bp_tgt_d = bp.target;
        state_d  = ST_BP_PEND;
      end
    end else if (accept) begin
      pc_d = pc_q + 32'd8;
    end
    bp_arm_d   = ~stall & ~br.e;
    last_acc_d = accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      state_q    <= ST_SEQ;
      bp_tgt_q   <= '0;
      bp_arm_q   <= 1'b0;
      last_acc_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      bp_tgt_q   <= bp_tgt_d;
      bp_arm_q   <= bp_arm_d;
      last_acc_q <= last_acc_d;
    end
  end

  fetch_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (reset),
    .push      (accept),
    .push_pc   (pc_q),
    .kill_push (kill_push),
    .kill_all  (kill_all),
    .pop       (ibus.inst_data_ok & ~reset),
    .head_pc   (head_pc),
    .head_kill (head_kill),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign current_pc1 = pc_q;
  assign current_pc2 = pc_q + 32'd4;
  assign resp_valid  = ibus.inst_data_ok & ~fifo_empty & ~head_kill & ~reset;
  assign resp_pc     = head_pc;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed redirect scenarios followed by random
// traffic, all checked cycle by cycle against a queue-based fetch model.
module tb_fetch_pc_gen;
  import fetch_pc_gen_pkg::*;

  localparam logic [31:0] RPC   = 32'hBFC0_0000;
  localparam int          DEPTH = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         stall = 1'b0;
  logic [32:0]  br_bus = '0;
  logic [32:0]  bp_bus = '0;
  logic [31:0]  current_pc1, current_pc2, resp_pc;
  logic         resp_valid;
  fetch_state_e state_dbg;

  fetch_pc_gen_if ibus ();

  fetch_pc_gen #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .br_bus      (br_bus),
    .bp_bus      (bp_bus),
    .current_pc1 (current_pc1),
    .current_pc2 (current_pc2),
    .ibus        (ibus),
    .resp_valid  (resp_valid),
    .resp_pc     (resp_pc),
    .state_dbg   (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the fetch address, an optional deferred prediction, and the
  // ordered list of outstanding requests as {killed, pc}.
  logic [31:0] m_pc = '0;
  bit          m_pend = 1'b0;
  logic [31:0] m_tgt = '0;
  bit          m_arm = 1'b0;
  bit          m_last = 1'b0;
  bit          m_known = 1'b0;
  bit          m_req = 1'b0;
  bit          m_dok = 1'b0;
  logic [32:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // driver: apply one cycle of inputs, then compare outputs against the model
  task automatic drive(input bit r, input bit s, input bit be, input logic [31:0] bt,
                       input bit pe, input logic [31:0] pt, input bit ao, input bit dok);
    reset  = r;
    stall  = s;
    br_bus = {be, bt};
    bp_bus = {pe, pt};
    m_req  = !r && !s && (exp_q.size() < DEPTH);
    m_dok  = dok && !r && (exp_q.size() > 0);
    ibus.inst_addr_ok = ao;
    ibus.inst_data_ok = m_dok;
    #1;
    chk1("inst_req", ibus.inst_req, m_req);
    if (m_known) begin
      chk("inst_addr", ibus.inst_addr, m_pc);
      chk("current_pc1", current_pc1, m_pc);
      chk("current_pc2", current_pc2, m_pc + 32'd4);
      chk("state", 32'(state_dbg), 32'(m_pend ? ST_BP_PEND : ST_SEQ));
    end
    chk1("resp_valid", resp_valid, m_dok && !exp_q[0][32]);
    if (m_dok) chk("resp_pc", resp_pc, exp_q[0][31:0]);
  endtask

  task automatic tick();
    bit acc, bp_live;
    @(posedge clk);
    if (reset) begin
      m_pc = RPC; m_pend = 1'b0; m_tgt = '0; m_arm = 1'b0; m_last = 1'b0;
      exp_q.delete();
      m_known = 1'b1;
    end else begin
      acc = m_req && ibus.inst_addr_ok;
      if (m_dok) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({1'b0, m_pc});
      bp_live = bp_bus[32] && m_arm && !m_pend;
      if (br_bus[32]) begin
        foreach (exp_q[i]) exp_q[i][32] = 1'b1;
        m_pc = br_bus[31:0];
        m_pend = 1'b0;
      end else if (m_pend) begin
        if (acc) begin m_pc = m_tgt; m_pend = 1'b0; end
      end else if (bp_live) begin
        if (m_last) begin
          m_pc = bp_bus[31:0];
          if (acc) exp_q[exp_q.size()-1][32] = 1'b1;
        end else if (acc) begin
          m_pc = bp_bus[31:0];
        end else begin
          m_pend = 1'b1;
          m_tgt = bp_bus[31:0];
        end
      end else if (acc) begin
        m_pc = m_pc + 32'd8;
      end
      m_arm = !stall && !br_bus[32];
      m_last = acc;
    end
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [31:0] t);
    drive(0, 0, 1, t, 0, 0, 0, 0); tick();
  endtask

  task automatic drain();
    for (int g = 0; g < 8 && exp_q.size() > 0; g++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
    end
  endtask

  initial begin
    ibus.inst_addr_ok = 1'b0;
    ibus.inst_data_ok = 1'b0;

    // reset state
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    chk1("rst_req", ibus.inst_req, 1'b0);
    chk1("rst_rv", resp_valid, 1'b0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    chk("rst_pc1", current_pc1, RPC);
    chk("rst_pc2", current_pc2, RPC + 32'd4);
    tick();

    // back-to-back sequential fetch after reset
    drive(0, 0, 0, 0, 0, 0, 1, 0); chk("s1_addr0", ibus.inst_addr, 32'hBFC0_0000); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 1); chk("s1_addr1", ibus.inst_addr, 32'hBFC0_0008);
    chk1("s1_rv0", resp_valid, 1'b1); chk("s1_rpc0", resp_pc, 32'hBFC0_0000); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 1); chk("s1_addr2", ibus.inst_addr, 32'hBFC0_0010);
    chk("s1_rpc1", resp_pc, 32'hBFC0_0008); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1); chk1("s1_rv2", resp_valid, 1'b1);
    chk("s1_rpc2", resp_pc, 32'hBFC0_0010); tick();

    // branch kills two outstanding requests
    redirect_to(32'h100);
    drive(0, 0, 0, 0, 0, 0, 1, 0); chk("s2_addr0", ibus.inst_addr, 32'h100); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0); chk("s2_addr1", ibus.inst_addr, 32'h108); tick();
    drive(0, 0, 1, 32'h400, 0, 0, 0, 0); chk1("s2_full", ibus.inst_req, 1'b0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1); chk("s2_addr_br", ibus.inst_addr, 32'h400);
    chk1("s2_kill0", resp_valid, 1'b0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 1); chk1("s2_kill1", resp_valid, 1'b0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1); chk1("s2_rv_tgt", resp_valid, 1'b1);
    chk("s2_rpc_tgt", resp_pc, 32'h400); tick();

    // armed prediction after hit pair accepted kills same-cycle request
    redirect_to(32'h200);
    drive(0, 0, 0, 0, 0, 0, 1, 0); chk("s3_addr0", ibus.inst_addr, 32'h200); tick();
    drive(0, 0, 0, 0, 1, 32'h800, 1, 0); chk("s3_addr1", ibus.inst_addr, 32'h208); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1); chk("s3_addr_bp", ibus.inst_addr, 32'h800);
    chk1("s3_rv0", resp_valid, 1'b1); chk("s3_rpc0", resp_pc, 32'h200); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1); chk1("s3_kill", resp_valid, 1'b0); tick();

    // armed prediction before hit pair accepted: deferred redirect
    redirect_to(32'h200);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 32'h800, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); chk("s4_pend", 32'(state_dbg), 32'(ST_BP_PEND));
    chk("s4_hold", ibus.inst_addr, 32'h200); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0); chk("s4_issue", ibus.inst_addr, 32'h200); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); chk("s4_addr_bp", ibus.inst_addr, 32'h800);
    chk("s4_seq", 32'(state_dbg), 32'(ST_SEQ)); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1); chk1("s4_nokill", resp_valid, 1'b1); tick();

    // stall with a held prediction
    redirect_to(32'h300);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 0, 1, 32'h900, 1, 0);
      chk1("s5_stall_req", ibus.inst_req, 1'b0);
      chk("s5_stall_pc", ibus.inst_addr, 32'h300);
      tick();
    end
    drive(0, 0, 0, 0, 1, 32'h900, 1, 0); chk("s5_unarmed", ibus.inst_addr, 32'h300); tick();
    drive(0, 0, 0, 0, 1, 32'h900, 1, 0); chk("s5_seq", ibus.inst_addr, 32'h308); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1); chk("s5_addr_bp", ibus.inst_addr, 32'h900); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1); chk1("s5_kill", resp_valid, 1'b0); tick();

    // branch beats armed prediction; sequential wrap
    redirect_to(32'hFFFF_FFF8);
    drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 1, 32'h500, 1, 32'h800, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1); chk("s6_br_wins", ibus.inst_addr, 32'h500);
    chk1("s6_kill", resp_valid, 1'b0); tick();
    redirect_to(32'hFFFF_FFF8);
    drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0); chk("s6_wrap", ibus.inst_addr, 32'h0);
    chk("s6_wrap_pc2", current_pc2, 32'h4); tick();
    drain();

    // reset mid-operation drops outstanding requests
    drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 1, 0); chk1("s7_rst_req", ibus.inst_req, 1'b0); tick();
    drive(1, 0, 0, 0, 0, 0, 1, 0); chk("s7_rst_pc", current_pc1, RPC); tick();
    drive(0, 0, 0, 0, 0, 0, 1, 0); chk1("s7_empty_req", ibus.inst_req, 1'b1); tick();
    drain();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 9) == 0, $urandom & 32'hFFFF_FFF8,
            $urandom_range(0, 3) == 0, $urandom & 32'hFFFF_FFF8,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
